multdiv_ctrl: RTL
=================

Name: multdiv_ctrl

Overview:
- Sequences the shared multiply and divide datapaths for the pipeline's execute stage.
- Accepts a mult/div request from the pipeline, then latches the operands and destination register.
- Fires a one-cycle start pulse into the selected unit and holds its operands stable while it runs.
- Waits for the unit's ready, and stalls the pipeline until the result or exception code has been handed to writeback.

Parameters:
TIMEOUT, 40, max WAIT cycles before forced exception completion
MIN_WAIT, 2, cycles after start pulse during which unit ready is ignored (stale ready from previous op)
RSTATUS_REG, 30, register index written on exception
MUL_EXC, 4, exception code for multiply
DIV_EXC, 5, exception code for divide

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
req_mult  in  1  start multiply (single-cycle pulse)
req_div  in  1  start divide (single-cycle pulse)
op_a  in  32  operand A / multiplicand / dividend
op_b  in  32  operand B / multiplier / divisor
dest_in  in  5  destination register index
unit_start_mult  out  1  one-cycle start pulse to multiplier (its control_mult)
unit_start_div  out  1  one-cycle start pulse to divider
unit_a  out  32  held operand A to both units
unit_b  out  32  held operand B to both units
mult_result  in  32  multiplier result
mult_exception  in  1  multiplier overflow
mult_ready  in  1  multiplier done
div_result  in  32  divider quotient
div_exception  in  1  divide by zero
div_ready  in  1  divider done
stall  out  1  freeze upstream pipeline
wb_valid  out  1  writeback data available
wb_data  out  32  result or exception code
wb_reg  out  5  writeback register index
wb_ack  in  1  writeback consumed
timeout_err  out  1  sticky flag: a timeout has occurred since reset

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high.
- Reset value: all outputs 0, state IDLE, timeout_err 0, counter 0.
- Reset takes priority over every other event. Reset mid-operation returns to IDLE with no start pulse and no writeback; a later ready from the abandoned op is ignored.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, request in cycle T:
  - if req_mult or req_div: latch op_a, op_b, dest_in and op type; go to LAUNCH at edge T+1.
  - If both requests are asserted, multiply wins and req_div is dropped.
- LAUNCH, cycle T+1: exactly one of unit_start_mult/unit_start_div is high for this single cycle; counter cleared; go to WAIT.
- WAIT:
  - counter increments each cycle.
  - Ready/result/exception of the non-selected unit are always ignored.
  - Ready of the selected unit is ignored while counter < MIN_WAIT.
  - Otherwise, on the selected unit's ready, capture the outputs and go to DONE:
    - no exception: wb_data = unit result, wb_reg = latched dest.
    - exception: wb_data = MUL_EXC or DIV_EXC, wb_reg = RSTATUS_REG.
  - If counter reaches TIMEOUT with no ready: capture the exception path for the op type, set timeout_err, go to DONE.
- DONE: wb_valid high; wb_data and wb_reg held stable until wb_ack is sampled high, then go to IDLE the next cycle. wb_ack is permitted in the first DONE cycle.
- unit_a/unit_b: driven from latched operands from LAUNCH through DONE; hold their last value in IDLE. Operands never change while a unit runs.
- stall = (state != IDLE). The request cycle itself is not stalled; the pipeline holds the instruction from T+1.
- Requests while not IDLE are ignored and never queued.
- Back-to-back ops: the IDLE cycle after DONE accepts a new request.
- dest_in = 0: the op completes normally with wb_reg = 0; the regfile discards the write.
- Minimum latency, request to wb_valid: 2 + MIN_WAIT + 1 cycles.

Test Plan:
- Multiply: req_mult, op_a=7, op_b=-3 (0xFFFFFFFD), dest 9; model asserts mult_ready 17 cycles after start with result 0xFFFFFFEB -> one start pulse at T+1; stall high T+1 until after ack; wb_valid with wb_data=0xFFFFFFEB, wb_reg=9; unit_a/unit_b constant throughout.
- Divide by zero: req_div, op_a=10, op_b=0; model returns div_exception with ready -> wb_reg=30, wb_data=5; only unit_start_div pulses.
- Stale ready and arbitration:
  - mult_ready held high from the previous op, new req_mult issued -> no completion before counter reaches MIN_WAIT.
  - req_mult and req_div in the same cycle -> only unit_start_mult pulses.
- Timeout: model never asserts ready, multiply -> after TIMEOUT cycles in WAIT, wb_reg=30, wb_data=4, timeout_err=1 and it stays 1 after the next op.
- Backpressure: wb_ack held low 5 cycles -> wb_valid/wb_data/wb_reg stable all 5 cycles; stall stays high; a req_div during DONE is ignored (no start pulse).
- Reset mid-WAIT: assert reset for 1 cycle at counter=5 -> next cycle all outputs 0, IDLE; late mult_ready produces no wb_valid; new request is accepted normally.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared multiply/divide units. It latches one request,
// pulses the selected unit, waits for its result (or a timeout), and holds it for writeback.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT     = 40,
  parameter int unsigned MIN_WAIT    = 2,
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned MUL_EXC     = 4,
  parameter int unsigned DIV_EXC     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_mult,
  input  logic        req_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  dest_in,
  output logic        unit_start_mult,
  output logic        unit_start_div,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic        mult_ready,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  input  logic        div_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  input  logic        wb_ack,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            is_mult_q, is_mult_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [4:0]      dest_q, dest_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  logic            timeout_err_q, timeout_err_d;

  logic            sel_ready, sel_exc;
  logic [31:0]     sel_result, exc_code;

  // Only the unit that was launched is ever listened to.
  always_comb begin
    sel_ready  = is_mult_q ? mult_ready     : div_ready;
    sel_exc    = is_mult_q ? mult_exception : div_exception;
    sel_result = is_mult_q ? mult_result    : div_result;
    exc_code   = is_mult_q ? 32'(MUL_EXC)   : 32'(DIV_EXC);
  end

  always_comb begin
    state_d       = state_q;
    is_mult_d     = is_mult_q;
    a_d           = a_q;
    b_d           = b_q;
    dest_d        = dest_q;
    cnt_d         = cnt_q;
    wb_data_d     = wb_data_q;
    wb_reg_d      = wb_reg_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_mult || req_div) begin
          is_mult_d = req_mult;
          a_d       = op_a;
          b_d       = op_b;
          dest_d    = dest_in;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // Early ready may be left over from the previous operation.
        if (sel_ready && (cnt_q >= CntW'(MIN_WAIT))) begin
          state_d = StDone;
          if (sel_exc) begin
            wb_data_d = exc_code;
            wb_reg_d  = 5'(RSTATUS_REG);
          end else begin
            wb_data_d = sel_result;
            wb_reg_d  = dest_q;
          end
        end else if (cnt_d == CntW'(TIMEOUT)) begin
          state_d       = StDone;
          wb_data_d     = exc_code;
          wb_reg_d      = 5'(RSTATUS_REG);
          timeout_err_d = 1'b1;
        end
      end
      StDone: begin
        if (wb_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      is_mult_q     <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      dest_q        <= '0;
      cnt_q         <= '0;
      wb_data_q     <= '0;
      wb_reg_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_mult_q     <= is_mult_d;
      a_q           <= a_d;
      b_q           <= b_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      wb_data_q     <= wb_data_d;
      wb_reg_q      <= wb_reg_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign unit_start_mult = (state_q == StLaunch) && is_mult_q;
  assign unit_start_div  = (state_q == StLaunch) && !is_mult_q;
  assign unit_a          = a_q;
  assign unit_b          = b_q;
  assign stall           = (state_q != StIdle);
  assign wb_valid        = (state_q == StDone);
  assign wb_data         = wb_data_q;
  assign wb_reg          = wb_reg_q;
  assign timeout_err     = timeout_err_q;

endmodule
